// File: rtl/zeroriscy_defines.sv
// Shared types for the instruction-memory responder: grant FSM states,
// wait-counter width and the response queue entry layout.
package zeroriscy_defines;

  localparam int WAIT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GWAIT = 1'b1
  } gnt_state_e;

  typedef struct packed {
    logic [31:0]       data;
    logic [WAIT_W-1:0] delay;
  } resp_t;

endpackage

// File: rtl/zeroriscy_instr_mem_resp_fifo.sv
// In-order response queue whose entries count their own delay down every cycle.
// Head is poppable once its delay is 0; pushes must respect full, pops respect head_ready.
module zeroriscy_instr_mem_resp_fifo
  import zeroriscy_defines::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  resp_t push_entry,
  input  logic  pop,
  output resp_t head,
  output logic  head_ready,
  output logic  full,
  output logic  nonempty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  resp_t         ent_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head       = ent_q[rd_q];
  assign nonempty   = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));
  assign head_ready = nonempty && (head.delay == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      // Every entry ages each cycle, including those stuck behind the head.
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].delay != '0) ent_q[i].delay <= ent_q[i].delay - 1'b1;
      end
      if (push) begin
        ent_q[wr_q] <= push_entry;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/zeroriscy_instr_mem_responder.sv
// Instruction memory model for a zeroriscy fetch port with programmable grant and rvalid latency.
// Grant is combinational; at most MAX_OUTSTANDING grants await rvalid, responses return in order.
module zeroriscy_instr_mem_responder
  import zeroriscy_defines::*;
#(
  parameter int MEM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic [WAIT_W-1:0] gnt_wait_i,
  input  logic [WAIT_W-1:0] rvalid_wait_i,
  input  logic              load_we_i,
  input  logic [31:0]       load_addr_i,
  input  logic [31:0]       load_wdata_i,
  output logic              busy_o
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]       mem [MEM_WORDS];
  gnt_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic              gnt, full, nonempty, head_ready;
  resp_t             head, push_entry;
  logic [31:0]       rdata_q;
  logic [AW-1:0]     fetch_idx, load_idx;
  logic              unused_addr_bits;

  assign fetch_idx        = instr_addr_i[AW+1:2];
  assign load_idx         = load_addr_i[AW+1:2];
  assign unused_addr_bits = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0],
                              load_addr_i[31:AW+2], load_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_idx] <= load_wdata_i;
  end

  // The wait counter expires on the cycle its decrement reaches 0, giving exactly N wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    case (state_q)
      IDLE: begin
        if (instr_req_i && !full) begin
          if (gnt_wait_i == '0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = gnt_wait_i;
            state_d = GWAIT;
          end
        end
      end
      GWAIT: begin
        if (!instr_req_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0 && !full) begin
            gnt     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (head_ready) rdata_q <= head.data;
    end
  end

  assign push_entry = '{data: mem[fetch_idx], delay: rvalid_wait_i};

  zeroriscy_instr_mem_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (instr_gnt_o),
    .push_entry (push_entry),
    .pop        (head_ready),
    .head       (head),
    .head_ready (head_ready),
    .full       (full),
    .nonempty   (nonempty)
  );

  // Grant is combinational from req, so it must be forced low while reset is held.
  assign instr_gnt_o    = gnt & rst_n;
  assign instr_rvalid_o = head_ready;
  assign instr_rdata_o  = head_ready ? head.data : rdata_q;
  assign busy_o         = nonempty || (state_q == GWAIT);

endmodule
